i1_event_capture: RTL and testbench

- Downstream consumer of the combinational i1 decode stage.
- Samples its 16 outputs every enabled cycle and detects any change against the last committed snapshot.
- Each change is pushed into a small FIFO as a timestamped event record; a valid/ready handshake drains it to the monitor/scoreboard side.
- Provides a sticky overflow flag and a saturating drop counter for lost events.

---
 rtl/i1_cap_pkg.sv | 48 ++++
 rtl/i1_cap_fifo.sv | 102 ++++++++++
 rtl/i1_event_capture.sv | 125 ++++++++++++
 tb/tb_i1_event_capture.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i1_cap_pkg.sv
// ---------------------------------------------------------------------------
// i1_cap_pkg
// Shared definitions for the i1 event-capture block.
//   - Bit positions of the 16-bit i1 decode vector. The vector is packed
//     MSB first as {V38_0, V30_0, V28_0, V37_0, V27_0..V27_4, V36_0, V35_0,
//     V34_0, V33_0, V32_0, V31_0, V29_0}.
//   - Default parameter values for the capture block.
//   - The event record layout {ts, vec} at the default timestamp width.
// ---------------------------------------------------------------------------
package i1_cap_pkg;

   localparam int VEC_W = 16;

   localparam int DEF_DEPTH  = 4;
   localparam int DEF_TS_W   = 12;
   localparam int DEF_DROP_W = 8;

   localparam int IDX_V29_0 = 0;
   localparam int IDX_V31_0 = 1;
   localparam int IDX_V32_0 = 2;
   localparam int IDX_V33_0 = 3;
   localparam int IDX_V34_0 = 4;
   localparam int IDX_V35_0 = 5;
   localparam int IDX_V36_0 = 6;
   localparam int IDX_V27_4 = 7;
   localparam int IDX_V27_3 = 8;
   localparam int IDX_V27_2 = 9;
   localparam int IDX_V27_1 = 10;
   localparam int IDX_V27_0 = 11;
   localparam int IDX_V37_0 = 12;
   localparam int IDX_V28_0 = 13;
   localparam int IDX_V30_0 = 14;
   localparam int IDX_V38_0 = 15;

   // Event record: timestamp in the upper bits, decode vector in the lower
   // bits. ev_data of the capture block uses this same ordering for any
   // timestamp width.
   typedef struct packed {
      logic [DEF_TS_W-1:0] ts;
      logic [VEC_W-1:0]    vec;
   } ev_rec_t;

   // Width of a packed event record for a given timestamp width.
   function automatic int rec_width(input int ts_w);
      return ts_w + VEC_W;
   endfunction

endpackage

// File: rtl/i1_cap_fifo.sv
// ---------------------------------------------------------------------------
// i1_cap_fifo
// Generic synchronous FIFO with a registered head output.
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   flush    in   synchronous empty; wins over push and pop
//   push     in   write wr_data (accepted when not full, or full with a pop)
//   pop      in   drop the head entry (ignored when empty)
//   wr_data  in   WIDTH data to write
//   rd_data  out  head entry, registered; zero while empty
//   full     out  occupancy == DEPTH
//   empty    out  occupancy == 0
//   count    out  occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two >= 2. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
// ---------------------------------------------------------------------------
module i1_cap_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 28
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      wr_ptr_next;
   logic [AW:0]      rd_ptr_next;
   logic [WIDTH-1:0] rd_data_reg;
   logic             do_push;
   logic             do_pop;

   assign count = wr_ptr_reg - rd_ptr_reg;
   assign full  = (count == DEPTH_C);
   assign empty = (wr_ptr_reg == rd_ptr_reg);

   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (do_push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage array: no reset so it maps onto RAM.
   always_ff @(posedge clock) begin
      if (do_push && !flush) begin
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
      end
   end

   // Head register is loaded from the next head address. When the entry
   // being written this cycle becomes the new head (the FIFO would otherwise
   // be empty after the pop), its data is taken from wr_data because the
   // array write has not landed yet.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_reg <= '0;
      end else if (flush || (wr_ptr_next == rd_ptr_next)) begin
         rd_data_reg <= '0;
      end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
         rd_data_reg <= wr_data;
      end else begin
         rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/i1_event_capture.sv
// ---------------------------------------------------------------------------
// i1_event_capture
// Watches the 16 outputs of the i1 decode stage and queues a timestamped
// record every time the sampled vector differs from the last committed
// snapshot. Records drain through a valid/ready handshake.
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   sample_en  in   sample dec_vec this cycle
//   dec_vec    in   packed i1 decode outputs (see i1_cap_pkg for bit map)
//   clear      in   synchronous flush of FIFO, drop accounting and snapshot;
//                   the timestamp keeps running
//   ev_valid   out  head record available
//   ev_ready   in   consumer takes the head record
//   ev_data    out  {timestamp, vector} of the head record
//   ev_count   out  FIFO occupancy
//   overflow   out  sticky: a record was lost
//   drop_cnt   out  number of lost records, saturating
// ---------------------------------------------------------------------------
module i1_event_capture
   import i1_cap_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int TS_W   = DEF_TS_W,
   parameter int DROP_W = DEF_DROP_W
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        sample_en,
   input  logic [VEC_W-1:0]            dec_vec,
   input  logic                        clear,
   output logic                        ev_valid,
   input  logic                        ev_ready,
   output logic [TS_W+VEC_W-1:0]       ev_data,
   output logic [$clog2(DEPTH):0]      ev_count,
   output logic                        overflow,
   output logic [DROP_W-1:0]           drop_cnt
);

   localparam int REC_W = rec_width(TS_W);
   localparam logic [TS_W-1:0]   TS_ONE   = TS_W'(1);
   localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   logic [TS_W-1:0]   ts_reg;
   logic [VEC_W-1:0]  snap_reg;
   logic              snap_valid_reg;
   logic              overflow_reg;
   logic [DROP_W-1:0] drop_cnt_reg;

   logic              change;
   logic              push_req;
   logic              pop;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [REC_W-1:0]  rec;

   // Without a committed snapshot every enabled sample counts as a change.
   assign change   = sample_en & (~snap_valid_reg | (dec_vec != snap_reg));
   assign push_req = change & ~clear;
   assign ev_valid = ~fifo_empty;
   assign pop      = ev_valid & ev_ready;
   // A simultaneous pop makes room, so only a full FIFO with no pop loses
   // the record.
   assign drop     = push_req & fifo_full & ~pop;
   assign rec      = {ts_reg, dec_vec};

   i1_cap_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (clear),
      .push    (push_req),
      .pop     (pop),
      .wr_data (rec),
      .rd_data (ev_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (ev_count)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ts_reg <= '0;
      end else begin
         ts_reg <= ts_reg + TS_ONE;
      end
   end

   // The snapshot follows every detected change, including dropped ones,
   // so the next change is measured against what was actually observed.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         snap_reg       <= '0;
         snap_valid_reg <= 1'b0;
      end else if (clear) begin
         snap_reg       <= '0;
         snap_valid_reg <= 1'b0;
      end else if (change) begin
         snap_reg       <= dec_vec;
         snap_valid_reg <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (clear) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (drop_cnt_reg != DROP_MAX) begin
            drop_cnt_reg <= drop_cnt_reg + DROP_ONE;
         end
      end
   end

   assign overflow = overflow_reg;
   assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_i1_event_capture.sv
// ---------------------------------------------------------------------------
// tb_i1_event_capture
// Self-checking bench for i1_event_capture (DEPTH=4, TS_W=4, DROP_W=3).
// A queue-based reference model tracks the expected FIFO contents and the
// drop accounting; one process compares every output after every clock edge
// and after reset assertion. Directed scenarios pin literal values, then a
// randomized phase exercises backpressure, clears, saturation and resets.
// ---------------------------------------------------------------------------
module tb_i1_event_capture;
   import i1_cap_pkg::*;

   localparam int DEPTH    = 4;
   localparam int TS_W     = 4;
   localparam int DROP_W   = 3;
   localparam int CW       = $clog2(DEPTH) + 1;
   localparam int TS_MOD   = 1 << TS_W;
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   logic                 clock     = 1'b0;
   logic                 reset_n   = 1'b0;
   logic                 sample_en = 1'b0;
   logic [15:0]          dec_vec   = 16'h0000;
   logic                 clear     = 1'b0;
   logic                 ev_ready  = 1'b0;
   logic                 ev_valid;
   logic [TS_W+15:0]     ev_data;
   logic [CW-1:0]        ev_count;
   logic                 overflow;
   logic [DROP_W-1:0]    drop_cnt;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clock = ~clock;

   i1_event_capture #(
      .DEPTH  (DEPTH),
      .TS_W   (TS_W),
      .DROP_W (DROP_W)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sample_en (sample_en),
      .dec_vec   (dec_vec),
      .clear     (clear),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_data   (ev_data),
      .ev_count  (ev_count),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          ts;
      logic [15:0] vec;
   } rec_t;

   rec_t        mq[$];
   int          m_ts   = 0;
   logic [15:0] m_snap = 16'h0000;
   bit          m_sv   = 1'b0;
   bit          m_ovf  = 1'b0;
   int          m_drop = 0;
   bit          m_pop;
   bit          m_chg;
   logic [19:0] m_head;
   rec_t        m_new;

   always begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
         mq.delete();
         m_ts   = 0;
         m_snap = 16'h0000;
         m_sv   = 1'b0;
         m_ovf  = 1'b0;
         m_drop = 0;
      end else begin
         m_pop = (mq.size() > 0) && ev_ready;
         m_chg = sample_en && (!m_sv || (dec_vec != m_snap));
         if (clear) begin
            mq.delete();
            m_snap = 16'h0000;
            m_sv   = 1'b0;
            m_ovf  = 1'b0;
            m_drop = 0;
         end else begin
            if (m_pop) mq.delete(0);
            if (m_chg) begin
               m_snap = dec_vec;
               m_sv   = 1'b1;
               if (mq.size() < DEPTH) begin
                  m_new.ts  = m_ts;
                  m_new.vec = dec_vec;
                  mq.push_back(m_new);
               end else begin
                  m_ovf = 1'b1;
                  if (m_drop < DROP_MAX) m_drop++;
               end
            end
         end
         m_ts = (m_ts + 1) % TS_MOD;
      end
      #1;
      check("model_ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
      check("model_ev_count", 32'(ev_count), 32'(mq.size()));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
      check("model_drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (mq.size() > 0) begin
         m_head = {4'(mq[0].ts), mq[0].vec};
         check("model_ev_data", 32'(ev_data), 32'(m_head));
      end else if (!reset_n) begin
         check("model_ev_data_rst", 32'(ev_data), 32'h0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clock);
      cyc++;
   endtask

   initial begin
      logic [15:0] v27_1;
      logic [19:0] held;
      v27_1 = 16'h0001 << IDX_V27_1;

      // Reset state
      repeat (3) step();
      check("rst_ev_valid", 32'(ev_valid), 32'h0);
      check("rst_ev_data",  32'(ev_data),  32'h0);
      check("rst_ev_count", 32'(ev_count), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'h0);

      // Constant input: a single event from the first sample
      reset_n   = 1'b1;
      cyc       = 0;
      sample_en = 1'b1;
      dec_vec   = 16'h0000;
      repeat (5) step();
      check("first_ev_count", 32'(ev_count), 32'd1);
      check("first_ev_valid", 32'(ev_valid), 32'd1);
      check("first_ev_data",  32'(ev_data),  32'h00000);

      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      check("first_drained", 32'(ev_count), 32'd0);

      // Six toggles of V27_1 into a 4-deep FIFO
      for (int i = 0; i < 6; i++) begin
         dec_vec = (i % 2 == 0) ? v27_1 : 16'h0000;
         step();
      end
      check("ovf_ev_count", 32'(ev_count), 32'd4);
      check("ovf_overflow", 32'(overflow), 32'd1);
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);

      // Full + pop + new change in the same cycle
      check("full_head_before", 32'(ev_data), 32'h60400);
      dec_vec  = v27_1;
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      check("full_pp_count",  32'(ev_count), 32'd4);
      check("full_pp_drop",   32'(drop_cnt), 32'd2);
      check("full_pp_head",   32'(ev_data),  32'h70000);

      // Backpressure then drain one per cycle
      sample_en = 1'b0;
      held = ev_data;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_data", 32'(ev_data), 32'(held));
      end
      ev_ready = 1'b1;
      step();
      check("drain1_data",  32'(ev_data),  32'h80400);
      check("drain1_count", 32'(ev_count), 32'd3);
      step();
      check("drain2_data",  32'(ev_data),  32'h90000);
      check("drain2_count", 32'(ev_count), 32'd2);
      step();
      check("drain3_data",  32'(ev_data),  32'hC0400);
      check("drain3_count", 32'(ev_count), 32'd1);
      step();
      check("drain4_valid", 32'(ev_valid), 32'd0);
      ev_ready = 1'b0;

      // Timestamp wrap: samples at ts 15 and 1
      while (cyc % TS_MOD != 15) step();
      sample_en = 1'b1;
      dec_vec   = 16'h8000;
      step();
      sample_en = 1'b0;
      step();
      sample_en = 1'b1;
      dec_vec   = 16'h0001;
      step();
      sample_en = 1'b0;
      check("wrap_count", 32'(ev_count), 32'd2);
      check("wrap_ts15",  32'(ev_data),  32'hF8000);
      ev_ready = 1'b1;
      step();
      check("wrap_ts1",   32'(ev_data),  32'h10001);
      step();
      ev_ready = 1'b0;

      // clear with 3 entries held and overflow set
      sample_en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         dec_vec = 16'h1111 * 16'(i);
         step();
      end
      check("clr_pre_count", 32'(ev_count), 32'd4);
      check("clr_pre_drop",  32'(drop_cnt), 32'd3);
      sample_en = 1'b0;
      ev_ready  = 1'b1;
      step();
      ev_ready  = 1'b0;
      check("clr_pre_count3", 32'(ev_count), 32'd3);
      check("clr_pre_ovf",    32'(overflow), 32'd1);
      clear     = 1'b1;
      sample_en = 1'b1;
      step();
      clear = 1'b0;
      check("clr_ev_valid", 32'(ev_valid), 32'd0);
      check("clr_ev_count", 32'(ev_count), 32'd0);
      check("clr_overflow", 32'(overflow), 32'd0);
      check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
      step();
      check("clr_resample_count", 32'(ev_count), 32'd1);
      check("clr_resample_vec",   32'(ev_data[15:0]), 32'h5555);

      // Reset in the middle of a drain
      dec_vec = 16'h0A0A; step();
      dec_vec = 16'h0B0B; step();
      dec_vec = 16'h0C0C; step();
      dec_vec = 16'h0D0D; step();
      check("mid_pre_drop", 32'(drop_cnt), 32'd1);
      sample_en = 1'b0;
      ev_ready  = 1'b1;
      step();
      #2 reset_n = 1'b0;
      #2;
      check("mid_rst_valid", 32'(ev_valid), 32'd0);
      check("mid_rst_count", 32'(ev_count), 32'd0);
      check("mid_rst_data",  32'(ev_data),  32'd0);
      check("mid_rst_ovf",   32'(overflow), 32'd0);
      check("mid_rst_drop",  32'(drop_cnt), 32'd0);
      step();
      step();
      reset_n   = 1'b1;
      cyc       = 0;
      ev_ready  = 1'b0;
      sample_en = 1'b1;
      step();
      check("post_rst_count", 32'(ev_count), 32'd1);
      check("post_rst_data",  32'(ev_data),  32'h00D0D);

      // Randomized phase, checked by the model every cycle
      for (int n = 0; n < 4000; n++) begin
         sample_en = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 2) == 0) dec_vec = dec_vec ^ (16'h0001 << $urandom_range(0, 15));
         if ((n % 200) < 100) ev_ready = ($urandom_range(0, 9) < 2);
         else                 ev_ready = ($urandom_range(0, 9) < 7);
         clear = ($urandom_range(0, 99) == 0);
         step();
         if ($urandom_range(0, 499) == 0) begin
            #2 reset_n = 1'b0;
            step();
            reset_n = 1'b1;
         end
      end

      clear     = 1'b0;
      sample_en = 1'b0;
      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
